// File: rtl/servo_pkg.sv
// Shared constants and arithmetic helpers for the servo PWM bank.
package servo_pkg;

    localparam int PERIOD_DEF    = 1000000;
    localparam int PULSE_MIN_DEF = 50000;
    localparam int PULSE_MAX_DEF = 100000;
    localparam int STEP_LSB_DEF  = 195;
    localparam int STEP_BIAS_DEF = 4;

    // Map a setpoint code linearly onto [pmin, pmax); result never exceeds pmax.
    function automatic longint sp_to_pulse(
        input longint code,
        input longint pmin,
        input longint pmax,
        input int     sp_w
    );
        return pmin + ((code * (pmax - pmin)) >> sp_w);
    endfunction

    // Saturate a signed pulse width into [lo, hi].
    function automatic longint clamp_pulse(
        input longint value,
        input longint lo,
        input longint hi
    );
        longint res;
        if (value < lo) begin
            res = lo;
        end else if (value > hi) begin
            res = hi;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: working width, frame-aligned shadow, enable latch,
// per-frame step with saturation and the output comparator.
module servo_pwm_channel
    import servo_pkg::*;
#(
    parameter int DUTY_W    = 17,
    parameter int STEP_W    = 3,
    parameter int STEP_BIAS = STEP_BIAS_DEF,
    parameter int STEP_LSB  = STEP_LSB_DEF,
    parameter int PULSE_MIN = PULSE_MIN_DEF,
    parameter int PULSE_MAX = PULSE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              wr_hit,
    input  logic [DUTY_W-1:0] wr_pulse,
    input  logic [STEP_W-1:0] step_code,
    input  logic              ch_en,
    input  logic [DUTY_W-1:0] cnt_next,
    output logic [DUTY_W-1:0] work,
    output logic              pwm
);

    // Wide enough that work plus the largest signed step cannot wrap.
    localparam int SUM_W = DUTY_W + STEP_W + 9;
    localparam logic [DUTY_W-1:0] PULSE_MID = DUTY_W'((PULSE_MIN + PULSE_MAX) / 2);

    logic [DUTY_W-1:0]       work_r;
    logic [DUTY_W-1:0]       shadow_r;
    logic                    en_q_r;
    logic                    pwm_r;

    logic signed [SUM_W-1:0] sum_s;
    logic [DUTY_W-1:0]       stepped_s;
    logic [DUTY_W-1:0]       work_next_s;
    logic [DUTY_W-1:0]       shadow_next_s;
    logic                    en_next_s;
    logic                    pwm_next_s;

    // Stepped candidate: work + (step - bias) * lsb, saturated to the window.
    always_comb begin
        sum_s = signed'(SUM_W'(work_r))
              + (signed'(SUM_W'(step_code)) - signed'(SUM_W'(STEP_BIAS)))
              * signed'(SUM_W'(STEP_LSB));
        stepped_s = DUTY_W'(clamp_pulse(longint'(sum_s),
                                        longint'(PULSE_MIN),
                                        longint'(PULSE_MAX)));
    end

    // Next-state: a write beats the step; shadow/enable latch only at frame end.
    // The comparator uses next-state values so a new frame starts with its new width.
    always_comb begin
        work_next_s   = work_r;
        shadow_next_s = shadow_r;
        en_next_s     = en_q_r;
        if (wr_hit) begin
            work_next_s = wr_pulse;
        end else if (tick) begin
            work_next_s = stepped_s;
        end else begin
            work_next_s = work_r;
        end
        if (tick) begin
            shadow_next_s = work_next_s;
            en_next_s     = ch_en;
        end else begin
            shadow_next_s = shadow_r;
            en_next_s     = en_q_r;
        end
        pwm_next_s = en_next_s && (cnt_next < shadow_next_s);
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r   <= PULSE_MID;
            shadow_r <= PULSE_MID;
            en_q_r   <= 1'b0;
            pwm_r    <= 1'b0;
        end else begin
            work_r   <= work_next_s;
            shadow_r <= shadow_next_s;
            en_q_r   <= en_next_s;
            pwm_r    <= pwm_next_s;
        end
    end

    assign work = work_r;
    assign pwm  = pwm_r;

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel hobby-servo PWM controller: shared frame counter, setpoint
// write decode with per-channel mirroring, one channel instance per servo.
module servo_pwm_bank
    import servo_pkg::*;
#(
    parameter int          N_CH        = 2,
    parameter int          PERIOD      = PERIOD_DEF,
    parameter int          PULSE_MIN   = PULSE_MIN_DEF,
    parameter int          PULSE_MAX   = PULSE_MAX_DEF,
    parameter int          SP_W        = 8,
    parameter int          STEP_W      = 3,
    parameter int          STEP_BIAS   = STEP_BIAS_DEF,
    parameter int          STEP_LSB    = STEP_LSB_DEF,
    parameter logic [15:0] INVERT_MASK = 16'b10,
    localparam int         WCH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int         DUTY_W      = $clog2(PERIOD + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WCH_W-1:0]         wr_ch,
    input  logic [SP_W-1:0]          wr_data,
    input  logic [N_CH*STEP_W-1:0]   step,
    input  logic [N_CH-1:0]          ch_en,
    output logic [N_CH-1:0]          pwm_out,
    output logic                     frame_tick,
    output logic [N_CH*DUTY_W-1:0]   duty
);

    localparam int CNT_W = $clog2(PERIOD);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;
    logic [CNT_W-1:0] cnt_next_s;

    // Frame counter wraps after PERIOD-1.
    always_comb begin
        if (cnt_r == CNT_W'(PERIOD - 1)) begin
            cnt_next_s = CNT_W'(0);
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Counter and registered last-cycle-of-frame flag (aligned with cnt).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= CNT_W'(0);
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            tick_r <= (cnt_next_s == CNT_W'(PERIOD - 1));
        end
    end

    assign frame_tick = tick_r;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [SP_W-1:0]   code_s;
        logic              wr_hit_s;
        logic [DUTY_W-1:0] wr_pulse_s;

        // Write decode: optional mirror of the code, then scale into the window.
        always_comb begin
            if (INVERT_MASK[c]) begin
                code_s = ~wr_data;
            end else begin
                code_s = wr_data;
            end
            wr_hit_s   = wr_en && (wr_ch == WCH_W'(c));
            wr_pulse_s = DUTY_W'(sp_to_pulse(longint'(code_s),
                                             longint'(PULSE_MIN),
                                             longint'(PULSE_MAX),
                                             SP_W));
        end

        servo_pwm_channel #(
            .DUTY_W    (DUTY_W),
            .STEP_W    (STEP_W),
            .STEP_BIAS (STEP_BIAS),
            .STEP_LSB  (STEP_LSB),
            .PULSE_MIN (PULSE_MIN),
            .PULSE_MAX (PULSE_MAX)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick_r),
            .wr_hit    (wr_hit_s),
            .wr_pulse  (wr_pulse_s),
            .step_code (step[c*STEP_W +: STEP_W]),
            .ch_en     (ch_en[c]),
            .cnt_next  (DUTY_W'(cnt_next_s)),
            .work      (duty[c*DUTY_W +: DUTY_W]),
            .pwm       (pwm_out[c])
        );
    end

endmodule
